// File: rtl/next_pc_sequencer.sv
// rtl/next_pc_sequencer.sv - fetch-side PC sequencer with 1-entry redirect buffer
// Optional delay-slot mode: define BRANCH_DELAY_SLOT_EN.
module next_pc_sequencer #(
    parameter int                 ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = 32'h0040_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    output logic              if_req,
    output logic [ADDR_W-1:0] if_addr,
    input  logic              if_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              redir_valid,
    output logic              redir_ready,
    input  logic [1:0]        redir_type,
    input  logic [25:0]       redir_imm,
    input  logic [ADDR_W-1:0] redir_reg,
    input  logic [ADDR_W-1:0] redir_pc_plus4,
    output logic              redirect_taken
);

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic DELAY_SLOT = 1'b1;
`else
    localparam logic DELAY_SLOT = 1'b0;
`endif

    typedef enum logic [1:0] {S_BOOT, S_REQ, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic              pend_slot_q, pend_slot_d;
    logic              redirect_taken_q, redirect_taken_d;

    logic [ADDR_W-1:0] new_target;
    logic              accept;
    logic              ack;

    assign if_req         = (state_q == S_REQ);
    assign if_addr        = pc_q;
    assign pc             = pc_q;
    assign pc_plus4       = pc_q + 32'd4;
    assign redir_ready    = (state_q != S_BOOT) && !pend_valid_q;
    assign redirect_taken = redirect_taken_q;

    assign accept = redir_valid && redir_ready && (redir_type != 2'b00);
    assign ack    = (state_q == S_REQ) && if_ack;

    always_comb begin
        new_target = redir_reg;
        case (redir_type)
            2'b01:   new_target = redir_pc_plus4 +
                                  {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};
            2'b10:   new_target = {redir_pc_plus4[31:28], redir_imm, 2'b00};
            default: new_target = redir_reg;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        pend_valid_d     = pend_valid_q;
        pend_target_d    = pend_target_q;
        pend_slot_d      = pend_slot_q;
        redirect_taken_d = 1'b0;

        // pend_slot_q marks a buffered redirect still owed one sequential fetch
        if (ack) begin
            if (pend_valid_q && !pend_slot_q) begin
                pc_d             = pend_target_q;
                pend_valid_d     = 1'b0;
                redirect_taken_d = 1'b1;
            end else if (pend_valid_q) begin
                pc_d        = pc_plus4;
                pend_slot_d = 1'b0;
            end else if (accept && !DELAY_SLOT) begin
                pc_d             = new_target;
                redirect_taken_d = 1'b1;
            end else if (accept) begin
                pc_d          = pc_plus4;
                pend_valid_d  = 1'b1;
                pend_target_d = new_target;
                pend_slot_d   = 1'b0;
            end else begin
                pc_d = pc_plus4;
            end
        end else if (accept) begin
            pend_valid_d  = 1'b1;
            pend_target_d = new_target;
            pend_slot_d   = DELAY_SLOT;
        end

        case (state_q)
            S_BOOT:  state_d = S_REQ;
            S_REQ:   if (ack && stall) state_d = S_HOLD;
            S_HOLD:  if (!stall) state_d = S_REQ;
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= S_BOOT;
            pc_q             <= RESET_VECTOR;
            pend_valid_q     <= 1'b0;
            pend_target_q    <= '0;
            pend_slot_q      <= 1'b0;
            redirect_taken_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            pend_valid_q     <= pend_valid_d;
            pend_target_q    <= pend_target_d;
            pend_slot_q      <= pend_slot_d;
            redirect_taken_q <= redirect_taken_d;
        end
    end

endmodule

// File: tb/tb_next_pc_sequencer.sv
// tb/tb_next_pc_sequencer.sv - directed and randomized bench for next_pc_sequencer
module tb_next_pc_sequencer;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam int DS = 1;
`else
    localparam int DS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redir_valid = 1'b0;
    logic        redir_ready;
    logic [1:0]  redir_type = 2'b00;
    logic [25:0] redir_imm = '0;
    logic [31:0] redir_reg = '0;
    logic [31:0] redir_pc_plus4 = '0;
    logic        redirect_taken;

    int checks = 0;
    int errors = 0;

    next_pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .pc(pc), .pc_plus4(pc_plus4),
        .redir_valid(redir_valid), .redir_ready(redir_ready),
        .redir_type(redir_type), .redir_imm(redir_imm),
        .redir_reg(redir_reg), .redir_pc_plus4(redir_pc_plus4),
        .redirect_taken(redirect_taken)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: fetch phase, PC, and a redirect owed a number of acks before it lands.
    int          m_phase;   // 0 boot, 1 fetching, 2 stalled
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_tgt;
    int          m_wait;
    bit          m_taken;

    function automatic logic [31:0] ref_target(input logic [1:0] t, input logic [25:0] imm,
                                               input logic [31:0] r, input logic [31:0] pp4);
        logic [15:0] off;
        off = imm[15:0];
        case (t)
            2'd1:    return pp4 + 32'($signed(off)) * 32'd4;
            2'd2:    return (pp4 & 32'hF000_0000) | (32'(imm) << 2);
            default: return r;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_pc = 32'h0040_0000; m_pend = 0; m_tgt = '0; m_wait = 0; m_taken = 0;
    endtask

    task automatic model_tick();
        bit acc, got;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc = (m_phase != 0) && !m_pend && redir_valid && (redir_type != 0);
        got = (m_phase == 1) && if_ack;
        m_taken = 0;
        if (acc) begin
            m_pend = 1;
            m_tgt  = ref_target(redir_type, redir_imm, redir_reg, redir_pc_plus4);
            m_wait = DS;
        end
        if (got) begin
            if (m_pend && m_wait == 0) begin
                m_pc = m_tgt; m_pend = 0; m_taken = 1;
            end else begin
                if (m_pend) m_wait = m_wait - 1;
                m_pc = m_pc + 32'd4;
            end
        end
        if (m_phase == 0) m_phase = 1;
        else if (m_phase == 1 && got && stall) m_phase = 2;
        else if (m_phase == 2 && !stall) m_phase = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; cyc(); cyc();
        checks++; if (if_req !== 1'b0) begin errors++; $display("FAIL reset_if_req got %b exp 0", if_req); end
        checks++; if (pc !== 32'h0040_0000) begin errors++; $display("FAIL reset_pc got %h exp 00400000", pc); end
        checks++; if (redir_ready !== 1'b0) begin errors++; $display("FAIL reset_redir_ready got %b exp 0", redir_ready); end
        checks++; if (redirect_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b exp 0", redirect_taken); end
    endtask

    task automatic test_sequential();
        rst_n = 1; if_ack = 1; cyc();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (if_req !== 1'b1 || if_addr !== 32'h0040_0000 + 32'(4 * i)) begin
                errors++; $display("FAIL seq_addr%0d got req=%b addr=%h exp %h", i, if_req, if_addr, 32'h0040_0000 + 32'(4 * i));
            end
            checks++; if (redirect_taken !== 1'b0) begin errors++; $display("FAIL seq_taken%0d got %b exp 0", i, redirect_taken); end
            if (i == 2) if_ack = 0;
            cyc();
        end
    endtask

    task automatic test_jump();
        checks++; if (redir_ready !== 1'b1) begin errors++; $display("FAIL jump_ready got %b exp 1", redir_ready); end
        redir_valid = 1; redir_type = 2'b10; redir_pc_plus4 = 32'h0040_0008; redir_imm = 26'h010_0004;
        cyc();
        redir_valid = 0;
        checks++; if (redir_ready !== 1'b0 || pc !== 32'h0040_0008) begin
            errors++; $display("FAIL jump_pending got ready=%b pc=%h exp ready=0 pc=00400008", redir_ready, pc); end
        if_ack = 1; cyc();
        if (DS != 0) begin
            checks++; if (pc !== 32'h0040_000C || redirect_taken !== 1'b0) begin
                errors++; $display("FAIL jump_slot got pc=%h taken=%b exp 0040000c/0", pc, redirect_taken); end
            cyc();
        end
        checks++; if (pc !== 32'h0040_0010 || redirect_taken !== 1'b1) begin
            errors++; $display("FAIL jump_target got pc=%h taken=%b exp 00400010/1", pc, redirect_taken); end
        cyc();
        checks++; if (pc !== 32'h0040_0014 || redirect_taken !== 1'b0) begin
            errors++; $display("FAIL jump_after1 got pc=%h taken=%b exp 00400014/0", pc, redirect_taken); end
        cyc();
        checks++; if (pc !== 32'h0040_0018) begin errors++; $display("FAIL jump_after2 got %h exp 00400018", pc); end
        if_ack = 0; cyc();
    endtask

    task automatic test_branch();
        redir_valid = 1; redir_type = 2'b01; redir_pc_plus4 = 32'h0040_0010; redir_imm = 26'h000_FFFE;
        if_ack = 1; cyc();
        redir_valid = 0;
        if (DS != 0) begin
            checks++; if (pc !== 32'h0040_001C) begin errors++; $display("FAIL branch_slot got %h exp 0040001c", pc); end
            cyc();
        end
        checks++; if (pc !== 32'h0040_0008 || redirect_taken !== 1'b1) begin
            errors++; $display("FAIL branch_target got pc=%h taken=%b exp 00400008/1", pc, redirect_taken); end
        if_ack = 0; cyc();
    endtask

    task automatic test_wrap();
        redir_valid = 1; redir_type = 2'b11; redir_reg = 32'hFFFF_FFFC; if_ack = 1; cyc();
        redir_valid = 0;
        if (DS != 0) cyc();
        checks++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            errors++; $display("FAIL wrap_jr got pc=%h pc_plus4=%h exp fffffffc/00000000", pc, pc_plus4); end
        cyc();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_seq got %h exp 00000000", pc); end
        redir_valid = 1; redir_type = 2'b01; redir_pc_plus4 = 32'hFFFF_FFFC; redir_imm = 26'h000_0001; cyc();
        redir_valid = 0;
        if (DS != 0) cyc();
        checks++; if (pc !== 32'h0 || redirect_taken !== 1'b1) begin
            errors++; $display("FAIL wrap_branch got pc=%h taken=%b exp 00000000/1", pc, redirect_taken); end
        if_ack = 0; cyc();
    endtask

    task automatic test_back_to_back();
        redir_valid = 1; redir_type = 2'b11; redir_reg = 32'h0000_1000; cyc();
        redir_reg = 32'h0000_2000;
        checks++; if (redir_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b exp 0", redir_ready); end
        if_ack = 1; cyc();
        if (DS != 0) cyc();
        checks++; if (pc !== 32'h0000_1000 || redirect_taken !== 1'b1 || redir_ready !== 1'b1) begin
            errors++; $display("FAIL bp_first got pc=%h taken=%b ready=%b exp 00001000/1/1", pc, redirect_taken, redir_ready); end
        if_ack = 0; cyc();
        redir_valid = 0;
        checks++; if (redir_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept got ready=%b exp 0", redir_ready); end
        if_ack = 1; cyc();
        if (DS != 0) cyc();
        checks++; if (pc !== 32'h0000_2000) begin errors++; $display("FAIL bp_second got %h exp 00002000", pc); end
        if_ack = 0; cyc();
    endtask

    task automatic test_stall();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (if_req !== 1'b1 || if_addr !== 32'h0000_2000) begin
                errors++; $display("FAIL stall_hold%0d got req=%b addr=%h exp 1/00002000", i, if_req, if_addr); end
        end
        if_ack = 1; cyc();
        checks++; if (if_req !== 1'b0 || pc !== 32'h0000_2004) begin
            errors++; $display("FAIL stall_enter got req=%b pc=%h exp 0/00002004", if_req, pc); end
        cyc();
        checks++; if (if_req !== 1'b0 || pc !== 32'h0000_2004) begin
            errors++; $display("FAIL stall_frozen got req=%b pc=%h exp 0/00002004", if_req, pc); end
        stall = 0; cyc();
        checks++; if (if_req !== 1'b1 || pc !== 32'h0000_2004) begin
            errors++; $display("FAIL stall_exit got req=%b pc=%h exp 1/00002004", if_req, pc); end
        if_ack = 0; cyc();
    endtask

    task automatic test_reset_mid_fetch();
        redir_valid = 1; redir_type = 2'b11; redir_reg = 32'h1234_5678; cyc();
        redir_valid = 0; rst_n = 0; cyc();
        checks++; if (if_req !== 1'b0 || pc !== 32'h0040_0000 || redir_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid got req=%b pc=%h ready=%b exp 0/00400000/0", if_req, pc, redir_ready); end
        rst_n = 1; if_ack = 1; cyc();
        checks++; if (if_addr !== 32'h0040_0000) begin errors++; $display("FAIL rstmid_first got %h exp 00400000", if_addr); end
        cyc();
        checks++; if (pc !== 32'h0040_0004 || redirect_taken !== 1'b0) begin
            errors++; $display("FAIL rstmid_discard got pc=%h taken=%b exp 00400004/0", pc, redirect_taken); end
        if_ack = 0;
    endtask

    task automatic test_random();
        rst_n = 0; model_reset(); cyc();
        for (int i = 0; i < 3000; i++) begin
            checks++;
            if (if_req !== (m_phase == 1) || if_addr !== m_pc || pc !== m_pc || pc_plus4 !== m_pc + 32'd4 ||
                redir_ready !== (m_phase != 0 && !m_pend) || redirect_taken !== m_taken) begin
                errors++;
                $display("FAIL rand_cycle%0d got req=%b pc=%h ready=%b taken=%b exp req=%b pc=%h ready=%b taken=%b",
                         i, if_req, pc, redir_ready, redirect_taken, m_phase == 1, m_pc, m_phase != 0 && !m_pend, m_taken);
            end
            rst_n          = ($urandom_range(0, 149) != 0);
            stall          = ($urandom_range(0, 9) < 3);
            if_ack         = $urandom_range(0, 1) == 1;
            redir_valid    = ($urandom_range(0, 3) == 0);
            redir_type     = 2'($urandom_range(0, 3));
            redir_imm      = 26'($urandom);
            redir_reg      = $urandom;
            redir_pc_plus4 = $urandom;
            model_tick();
            cyc();
        end
        rst_n = 1; stall = 0; if_ack = 0; redir_valid = 0;
    endtask

    initial begin
        #1;
        test_reset();
        test_sequential();
        test_jump();
        test_branch();
        test_wrap();
        test_back_to_back();
        test_stall();
        test_reset_mid_fetch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
